// File: rtl/apb_rr_pkg.sv
// rtl/apb_rr_pkg.sv - shared state encoding and default sizes for the round-robin APB master
package apb_rr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    localparam int APB_AW_DEF      = 3;
    localparam int APB_DW_DEF      = 32;
    localparam int APB_TIMEOUT_DEF = 16;

    // Timeout counter is never narrower than 5 bits so TIMEOUT=16 fits with headroom.
    function automatic int tmo_cnt_width(input int tmo);
        return ($clog2(tmo + 1) > 5) ? $clog2(tmo + 1) : 5;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-priority arbiter that owns the round-robin pointer
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_en,
    input  logic            i_advance,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_grant_idx,
    output logic            o_any
);

    logic [IW-1:0] r_ptr;
    logic [IW:0]   w_cand;
    logic          w_found;
    logic [IW-1:0] w_idx;

    // Pointer moves one past whoever was just served, wrapping at NREQ-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (i_last == IW'(NREQ - 1)) ? '0 : i_last + 1'b1;
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, r_ptr} + (IW + 1)'(k);
            if (w_cand >= (IW + 1)'(NREQ)) begin
                w_cand = w_cand - (IW + 1)'(NREQ);
            end
            if (!w_found && i_req[w_cand[IW-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_cand[IW-1:0];
            end
        end
    end

    assign o_any       = i_en && w_found;
    assign o_grant     = o_any ? (NREQ'(1) << w_idx) : '0;
    assign o_grant_idx = w_idx;

endmodule

// File: rtl/apb_rr_master.sv
// rtl/apb_rr_master.sv - round-robin APB master sharing one slave among NREQ requesters
// Optional ACCESS timeout is enabled by defining APB_RR_TIMEOUT_EN.
module apb_rr_master
    import apb_rr_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = APB_AW_DEF,
    parameter int DW      = APB_DW_DEF,
    parameter int TIMEOUT = APB_TIMEOUT_DEF
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [AW-1:0]      PADDR,
    output logic [DW-1:0]      PWDATA,
    input  logic [DW-1:0]      PRDATA,
    input  logic               PREADY
);

    localparam int IW = $clog2(NREQ);

    apb_state_t      r_state;
    apb_state_t      w_next_state;
    logic            r_pwrite;
    logic [AW-1:0]   r_paddr;
    logic [DW-1:0]   r_pwdata;
    logic [IW-1:0]   r_winner;
    logic [NREQ-1:0] r_rsp_valid;
    logic [DW-1:0]   r_rsp_rdata;

    logic            w_arb_en;
    logic            w_any;
    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_grant_idx;
    logic            w_done;
    logic            w_finish;

    // Gating with PRESETn keeps req_ready low while the block is held in reset.
    assign w_arb_en = (r_state == ST_IDLE) && PRESETn;
    assign w_done   = (r_state == ST_ACCESS) && PREADY;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .clk         (PCLK),
        .rst_n       (PRESETn),
        .i_req       (req_valid),
        .i_en        (w_arb_en),
        .i_advance   (w_finish),
        .i_last      (r_winner),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

`ifdef APB_RR_TIMEOUT_EN
    localparam int CW = tmo_cnt_width(TIMEOUT);

    logic [CW-1:0] r_tcnt;
    logic          r_rsp_err;
    logic          w_abort;

    assign w_abort  = (r_state == ST_ACCESS) && !PREADY && (r_tcnt == CW'(TIMEOUT - 1));
    assign w_finish = w_done || w_abort;
    assign rsp_err  = r_rsp_err;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_tcnt    <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_err <= w_abort;
            if (r_state == ST_SETUP) begin
                r_tcnt <= '0;
            end else if ((r_state == ST_ACCESS) && !PREADY) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end
`else
    assign w_finish = w_done;
    assign rsp_err  = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        PSEL         = 1'b0;
        PENABLE      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) w_next_state = ST_SETUP;
            end
            ST_SETUP: begin
                PSEL         = 1'b1;
                w_next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (w_finish) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request fields are captured only on the accept edge; later changes are ignored.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= ST_IDLE;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_winner    <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_next_state;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            if (w_any) begin
                r_pwrite <= req_write[w_grant_idx];
                r_paddr  <= req_addr[w_grant_idx*AW +: AW];
                r_pwdata <= req_wdata[w_grant_idx*DW +: DW];
                r_winner <= w_grant_idx;
            end
            if (w_finish) begin
                r_rsp_valid <= NREQ'(1) << r_winner;
                r_rsp_rdata <= (w_done && !r_pwrite) ? PRDATA : '0;
            end
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_rr_master.sv
// tb/tb_apb_rr_master.sv - self-checking bench for apb_rr_master with a registered-ready slave model
module tb_apb_rr_master;

    localparam int NREQ = 4;
    localparam int AW   = 3;
    localparam int DW   = 32;
    localparam int TMO  = 16;

    logic               PCLK = 1'b0;
    logic               PRESETn;
    logic [NREQ-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]      rsp_rdata, PWDATA, PRDATA;
    logic               rsp_err, PSEL, PENABLE, PWRITE, PREADY;
    logic [AW-1:0]      PADDR;

    apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Slave: PREADY after slv_lat ACCESS cycles; slv_stale drives PREADY high outside ACCESS.
    logic [DW-1:0] slv_mem [8] = '{default: '0};
    int slv_lat   = 1;
    bit slv_stale = 1'b0;
    int acc_cnt   = 0;
    assign PREADY = (PSEL && PENABLE && (acc_cnt >= slv_lat)) || (slv_stale && !PENABLE);
    assign PRDATA = slv_mem[PADDR];
    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) slv_mem[PADDR] <= PWDATA;
    end

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    typedef struct {
        int          idx;
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    exp_t        sb[$];
    logic [31:0] exp_mem [8];
    int          n_pass = 0;
    int          n_total = 0;
    bit          done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic push_exp(input int idx, input logic [31:0] rd, input int acc);
        exp_t e;
        e.idx = idx; e.rdata = rd; e.err = 1'b0; e.due = acc + 3 + slv_lat;
`ifdef APB_RR_TIMEOUT_EN
        if (slv_lat >= TMO) begin
            e.err = 1'b1; e.rdata = '0; e.due = acc + 2 + TMO;
        end
`endif
        sb.push_back(e);
    endtask

    task automatic issue(input int idx, input bit wr, input logic [2:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd);
        bit got = 1'b0;
        @(negedge PCLK);
        req_valid[idx] = 1'b1; req_write[idx] = wr;
        req_addr[idx*AW +: AW] = a; req_wdata[idx*DW +: DW] = d;
        for (int k = 0; k < 50 && !got; k++) begin
            #1;
            if (req_ready[idx]) got = 1'b1;
            else @(negedge PCLK);
        end
        if (!got) begin
            fail_now("accept");
            req_valid[idx] = 1'b0;
            return;
        end
        chk("req_ready_onehot", req_ready, 32'(1) << idx);
        push_exp(idx, wr ? 32'h0 : exp_rd, cyc);
        @(posedge PCLK); #1;
        req_valid[idx] = 1'b0; req_write[idx] = ~wr;
        req_addr[idx*AW +: AW] = ~a; req_wdata[idx*DW +: DW] = ~d;
    endtask

    task automatic check_phases(input logic [2:0] a, input bit wr, input logic [31:0] d);
        bit ps [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        bit en [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("psel_c%0d", j + 1), PSEL, ps[j]);
            chk($sformatf("penable_c%0d", j + 1), PENABLE, en[j]);
            if (j < 3) begin
                chk("paddr", PADDR, a);
                chk("pwrite", PWRITE, wr);
                if (wr) chk("pwdata", PWDATA, d);
            end
            @(posedge PCLK); #1;
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) begin
            @(negedge PCLK); #2;
        end
        if (sb.size() != 0) fail_now("rsp_drain");
    endtask

    task automatic run_multi(input logic [NREQ-1:0] mask, input int n_each, input int e0, input int e1);
        int rem [NREQ];
        int k = 0, c = 0, g = 0, last_acc = 0;
        @(negedge PCLK);
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = mask[i] ? n_each : 0;
            if (mask[i]) begin
                req_valid[i] = 1'b1; req_write[i] = 1'b0; req_addr[i*AW +: AW] = 3'(i);
            end
        end
        while (k < 2 * n_each && c < 200) begin
            #1;
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                chk("grant_onehot", $countones(req_ready), 1);
                chk($sformatf("grant_order_%0d", k), g, (k % 2 == 0) ? e0 : e1);
                if (k > 0) chk("throughput", cyc - last_acc, 4);
                last_acc = cyc;
                push_exp(g, exp_mem[g], cyc);
                rem[g]--; k++;
                @(posedge PCLK); #1;
                if (rem[g] == 0) req_valid[g] = 1'b0;
            end
            @(negedge PCLK); c++;
        end
        if (k < 2 * n_each) fail_now("grant_count");
        req_valid = '0;
    endtask

    vec_t tbl [9];

    initial begin
        PRESETn = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 8; i++) exp_mem[i] = '0;
        tbl[0] = '{0, 1'b1, 3'd5, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{0, 1'b0, 3'd5, 32'h0,       32'hDEADBEEF};
        tbl[2] = '{1, 1'b1, 3'd0, 32'h11111111, 32'h0};
        tbl[3] = '{2, 1'b1, 3'd7, 32'hA5A5A5A5, 32'h0};
        tbl[4] = '{3, 1'b0, 3'd0, 32'h0,       32'h11111111};
        tbl[5] = '{1, 1'b0, 3'd7, 32'h0,       32'hA5A5A5A5};
        tbl[6] = '{3, 1'b1, 3'd5, 32'h12345678, 32'h0};
        tbl[7] = '{2, 1'b0, 3'd5, 32'h0,       32'h12345678};
        tbl[8] = '{0, 1'b0, 3'd3, 32'h0,       32'h0};

        fork
            begin : monitor
                exp_t e;
                while (!done) begin
                    @(negedge PCLK);
                    if (PRESETn && rsp_valid != '0) begin
                        if (sb.size() == 0) begin
                            chk("rsp_unexpected", rsp_valid, '0);
                        end else begin
                            e = sb.pop_front();
                            chk("rsp_valid", rsp_valid, 32'(1) << e.idx);
                            chk("rsp_rdata", rsp_rdata, e.rdata);
                            chk("rsp_err", rsp_err, e.err);
                            chk("rsp_latency", cyc, e.due);
                        end
                    end
                end
            end
            begin : stimulus
                repeat (3) @(negedge PCLK);
                chk("rst_psel", PSEL, 0);
                chk("rst_penable", PENABLE, 0);
                chk("rst_pwrite", PWRITE, 0);
                chk("rst_paddr", PADDR, 0);
                chk("rst_pwdata", PWDATA, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_rdata", rsp_rdata, 0);
                chk("rst_rsp_err", rsp_err, 0);
                PRESETn = 1'b1;

                slv_stale = 1'b1;
                foreach (tbl[i]) begin
                    if (tbl[i].wr) exp_mem[tbl[i].addr] = tbl[i].wdata;
                    issue(tbl[i].idx, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);
                    check_phases(tbl[i].addr, tbl[i].wr, tbl[i].wdata);
                    wait_drain();
                end
                slv_stale = 1'b0;

                // Last table transfer was requester 0, so requester 1 goes first.
                run_multi(4'b0011, 4, 1, 0);
                wait_drain();

                issue(1, 1'b0, 3'd1, 32'h0, exp_mem[1]);
                wait_drain();
                run_multi(4'b1010, 2, 3, 1);
                wait_drain();

                slv_lat = 10;
                exp_mem[4] = 32'hCAFE0004;
                issue(0, 1'b1, 3'd4, 32'hCAFE0004, 32'h0);
                chk("stall_setup", {PSEL, PENABLE}, 2'b10);
                for (int j = 0; j < 11; j++) begin
                    @(posedge PCLK); #1;
                    chk("stall_access", {PSEL, PENABLE}, 2'b11);
                    chk("stall_paddr", PADDR, 3'd4);
                    chk("stall_pwdata", PWDATA, 32'hCAFE0004);
                end
                @(posedge PCLK); #1;
                chk("stall_end_psel", PSEL, 0);
                wait_drain();
                slv_lat = 1;
                issue(3, 1'b0, 3'd4, 32'h0, exp_mem[4]);
                wait_drain();

                // Leave the pointer at 2, then reset in the middle of a requester-2 write.
                issue(1, 1'b0, 3'd1, 32'h0, exp_mem[1]);
                wait_drain();
                issue(2, 1'b1, 3'd2, 32'h0BAD0002, 32'h0);
                @(posedge PCLK); #1;
                chk("mid_penable", PENABLE, 1);
                PRESETn = 1'b0;
                #1;
                chk("mid_rst_psel", PSEL, 0);
                chk("mid_rst_penable", PENABLE, 0);
                chk("mid_rst_rsp_valid", rsp_valid, 0);
                chk("mid_rst_paddr", PADDR, 0);
                chk("mid_rst_pwdata", PWDATA, 0);
                sb.delete();
                repeat (2) @(negedge PCLK);
                PRESETn = 1'b1;
                repeat (6) @(negedge PCLK);
                run_multi(4'b1010, 1, 1, 3);
                wait_drain();
                issue(0, 1'b0, 3'd2, 32'h0, exp_mem[2]);
                wait_drain();

`ifdef APB_RR_TIMEOUT_EN
                slv_lat = 1000;
                issue(1, 1'b0, 3'd5, 32'h0, exp_mem[5]);
                wait_drain();
                slv_lat = 1;
                issue(1, 1'b0, 3'd5, 32'h0, exp_mem[5]);
                wait_drain();
`endif

                repeat (4) @(negedge PCLK);
                chk("sb_empty", sb.size(), 0);
                done = 1'b1;
            end
        join
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin APB master that shares one 8-entry, 32-bit APB register-file slave between NREQ local requesters.
- Accepts one request at a time and sequences the APB SETUP/ACCESS phases.
- Waits for PREADY, then returns a per-requester response pulse with read data.
- Sits between on-chip clients (CPU shim, DMA, debug) and the slave's PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY pins.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 3, APB address width (8 words).
- DW, 32, APB data width.
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY (used only with the optional feature).

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request; held until its req_ready.
- req_write  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data.
- req_ready  out  NREQ  one-hot accept strobe (combinational).
- rsp_valid  out  NREQ  one-hot, one-cycle completion pulse (registered).
- rsp_rdata  out  DW  read data, valid with rsp_valid.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  AW  APB address.
- PWDATA  out  DW  APB write data.
- PRDATA  in  DW  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Reset (async, PRESETn low):
  - Forces state IDLE and rr pointer 0.
  - All outputs 0, including PADDR/PWDATA/PWRITE/rsp_rdata.
  - Any in-flight transfer is dropped with no rsp_valid. Reset mid-ACCESS gives no response.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE: if any req_valid, winner = first set bit searching upward from ptr, wrapping at NREQ-1. req_ready[winner]=1 this cycle only when in IDLE. At the edge, latch write/addr/wdata into PWRITE/PADDR/PWDATA and the winner index, then go to SETUP.
  - SETUP: PSEL=1, PENABLE=0; exactly one cycle; PREADY ignored; go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1; stay until PREADY=1 is sampled. On that edge: go to IDLE, ptr = (winner+1) mod NREQ, rsp_valid[winner]=1 the next cycle. rsp_rdata = PRDATA for reads, 0 for writes. rsp_err = 0.
- In IDLE, PSEL=PENABLE=0 and PADDR/PWDATA/PWRITE hold their last values.
- Always at least one IDLE cycle between transfers; stale PREADY in IDLE/SETUP is ignored.
- Latency against the team slave (registered PREADY), with accept edge = cycle 0:
  - SETUP in cycle 1, ACCESS in cycles 2–3, PREADY seen in cycle 3, rsp_valid in cycle 4.
  - Max throughput is 1 transfer per 4 cycles.
- Request fields are sampled only at the accept edge; changes afterwards have no effect.
- req_valid dropped before accept means no transfer.
- Simultaneous requests: exactly one grant. The ptr rotation guarantees each of NREQ requesters is served within NREQ transfers.
- Single requester: repeatedly granted; ptr still advances.
- rsp_valid and req_ready for the same requester may be high in the same cycle only if a new IDLE accept coincides. Both are legal.

Optional Feature:
- Macro APB_RR_TIMEOUT_EN.
- Defined:
  - 5-bit-or-wider counter clears on SETUP→ACCESS and increments each ACCESS cycle without PREADY.
  - When the count reaches TIMEOUT: abort to IDLE (PSEL/PENABLE drop), rsp_valid[winner] pulse, rsp_err=1, rsp_rdata=0, ptr advances.
- Not defined: ACCESS waits indefinitely; rsp_err tied 0; no counter logic.

Decomposition:
- Package apb_rr_pkg:
  - state enum (IDLE, SETUP, ACCESS).
  - default AW/DW constants.
  - TIMEOUT default.
- Sub-module rr_arbiter:
  - Parameter NREQ.
  - Inputs: req vector, ptr, grant enable.
  - Outputs: one-hot grant and encoded index.
  - Owns the ptr register with an advance strobe.

Test Plan:
- Single write then read: req0 write addr 5 data 0xDEADBEEF, then read addr 5 → PSEL cycles 1–3, PENABLE cycles 2–3, rsp_valid[0] at cycle 4; read rsp_rdata=0xDEADBEEF, rsp_err=0.
- Contention: req0 and req1 both held high with 4 reads each → grants alternate 0,1,0,1,…; no requester starved; ptr=0 after the 8th.
- Fairness wrap, NREQ=4: only req3 and req1 valid, ptr=2 → grant 3, then 1, then 3.
- Reset mid-ACCESS: PRESETn low during cycle 2 of a write to addr 2 → PSEL/PENABLE/rsp_valid go 0 immediately; no rsp after reset release; next grant from ptr 0.
- Stalled slave: PREADY held 0 for 10 cycles, then 1 → ACCESS lasts 11 cycles; address/data stable throughout; single rsp_valid.
- APB_RR_TIMEOUT_EN with TIMEOUT=16: PREADY stuck 0 → abort after 16 ACCESS cycles; rsp_err=1, rsp_rdata=0; next request proceeds normally.
